pe_array_result_drain: RTL

Result-side counterpart of the PE_array input feed. On a capture strobe it snapshots the 64 per-PE outputs or the 4 row-scalar outputs for the current column, then streams them out as a tagged valid/ready word stream. The stream feeds the result buffer, and the word address uses the same column-major layout as the input and parameter buffers (col*64 + pe). It also counts completed columns and flags overflow when a capture is dropped.

---
 rtl/pe_array_pkg.sv | 16 +
 rtl/pe_array_result_drain.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pe_array_pkg.sv
// Shared parameters and drain FSM state type for the PE array result path.
package pe_array_pkg;
  localparam int DATA_W     = 32;
  localparam int NUM_PE     = 64;
  localparam int NUM_ROW    = 4;
  localparam int NUM_COL    = 8;
  localparam int PE_PER_ROW = 16;
  localparam int ADDR_W     = $clog2(NUM_COL * NUM_PE);
  localparam int IDX_W      = $clog2(NUM_PE);
  localparam int COL_W      = $clog2(NUM_COL);

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } drain_state_e;
endpackage

// File: rtl/pe_array_result_drain.sv
// Snapshots one column of PE (or row-scalar) results on Capture and streams them
// to the result buffer as an addressed valid/ready word stream.
module pe_array_result_drain
  import pe_array_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Out0_0,  Out0_1,  Out0_2,  Out0_3,
  input  logic [DATA_W-1:0] Out0_4,  Out0_5,  Out0_6,  Out0_7,
  input  logic [DATA_W-1:0] Out0_8,  Out0_9,  Out0_10, Out0_11,
  input  logic [DATA_W-1:0] Out0_12, Out0_13, Out0_14, Out0_15,
  input  logic [DATA_W-1:0] Out1_0,  Out1_1,  Out1_2,  Out1_3,
  input  logic [DATA_W-1:0] Out1_4,  Out1_5,  Out1_6,  Out1_7,
  input  logic [DATA_W-1:0] Out1_8,  Out1_9,  Out1_10, Out1_11,
  input  logic [DATA_W-1:0] Out1_12, Out1_13, Out1_14, Out1_15,
  input  logic [DATA_W-1:0] Out2_0,  Out2_1,  Out2_2,  Out2_3,
  input  logic [DATA_W-1:0] Out2_4,  Out2_5,  Out2_6,  Out2_7,
  input  logic [DATA_W-1:0] Out2_8,  Out2_9,  Out2_10, Out2_11,
  input  logic [DATA_W-1:0] Out2_12, Out2_13, Out2_14, Out2_15,
  input  logic [DATA_W-1:0] Out3_0,  Out3_1,  Out3_2,  Out3_3,
  input  logic [DATA_W-1:0] Out3_4,  Out3_5,  Out3_6,  Out3_7,
  input  logic [DATA_W-1:0] Out3_8,  Out3_9,  Out3_10, Out3_11,
  input  logic [DATA_W-1:0] Out3_12, Out3_13, Out3_14, Out3_15,
  input  logic [DATA_W-1:0] Scalar_output0,
  input  logic [DATA_W-1:0] Scalar_output1,
  input  logic [DATA_W-1:0] Scalar_output2,
  input  logic [DATA_W-1:0] Scalar_output3,
  input  logic              Capture,
  input  logic [COL_W-1:0]  Capture_col,
  input  logic              Scalar_mode,
  output logic              Res_valid,
  input  logic              Res_ready,
  output logic [DATA_W-1:0] Res_data,
  output logic [ADDR_W-1:0] Res_addr,
  output logic              Res_last,
  output logic              Busy,
  output logic              Frame_done,
  output logic              Overflow
);

  localparam int CNT_W = COL_W + 1;

  logic [NUM_PE-1:0][DATA_W-1:0]  pe_in;
  logic [NUM_ROW-1:0][DATA_W-1:0] sc_in;

  // Word index r*16+k: Out3_15 lands in the top slot.
  assign pe_in = {
    Out3_15, Out3_14, Out3_13, Out3_12, Out3_11, Out3_10, Out3_9, Out3_8,
    Out3_7,  Out3_6,  Out3_5,  Out3_4,  Out3_3,  Out3_2,  Out3_1, Out3_0,
    Out2_15, Out2_14, Out2_13, Out2_12, Out2_11, Out2_10, Out2_9, Out2_8,
    Out2_7,  Out2_6,  Out2_5,  Out2_4,  Out2_3,  Out2_2,  Out2_1, Out2_0,
    Out1_15, Out1_14, Out1_13, Out1_12, Out1_11, Out1_10, Out1_9, Out1_8,
    Out1_7,  Out1_6,  Out1_5,  Out1_4,  Out1_3,  Out1_2,  Out1_1, Out1_0,
    Out0_15, Out0_14, Out0_13, Out0_12, Out0_11, Out0_10, Out0_9, Out0_8,
    Out0_7,  Out0_6,  Out0_5,  Out0_4,  Out0_3,  Out0_2,  Out0_1, Out0_0
  };
  assign sc_in = {Scalar_output3, Scalar_output2, Scalar_output1, Scalar_output0};

  drain_state_e                  state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic                          mode_q, mode_d;
  logic [NUM_PE-1:0][DATA_W-1:0] snap_q, snap_d;
  logic                          overflow_q, overflow_d;
  logic                          frame_done_q, frame_done_d;
  logic [CNT_W-1:0]              col_cnt_q, col_cnt_d;

  logic             draining, hs, fin, load, drop;
  logic [IDX_W-1:0] last_idx;

  assign draining = (state_q == ST_DRAIN);
  assign last_idx = mode_q ? IDX_W'(NUM_ROW - 1) : IDX_W'(NUM_PE - 1);
  assign hs       = draining & Res_ready;
  assign fin      = hs & (idx_q == last_idx);
  // A new capture is accepted when idle or on the final handshake (no bubble).
  assign load     = Capture & (~draining | fin);
  assign drop     = Capture & draining & ~fin;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    col_d        = col_q;
    mode_d       = mode_q;
    snap_d       = snap_q;
    overflow_d   = overflow_q | drop;
    frame_done_d = fin & (col_q == COL_W'(NUM_COL - 1));
    col_cnt_d    = col_cnt_q;

    if (fin) begin
      col_cnt_d = (col_q == COL_W'(NUM_COL - 1)) ? '0 : col_cnt_q + CNT_W'(1);
    end

    if (load) begin
      state_d = ST_DRAIN;
      idx_d   = '0;
      col_d   = Capture_col;
      mode_d  = Scalar_mode;
      if (Scalar_mode) begin
        for (int i = 0; i < NUM_ROW; i++) snap_d[i] = sc_in[i];
      end else begin
        snap_d = pe_in;
      end
    end else if (fin) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (hs) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      col_q        <= '0;
      mode_q       <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      col_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      mode_q       <= mode_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      col_cnt_q    <= col_cnt_d;
    end
  end

  // Snapshot contents are only observed while draining, so it carries no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign Res_valid  = draining;
  assign Busy       = draining;
  assign Res_data   = draining ? snap_q[idx_q] : '0;
  assign Res_addr   = draining ? ADDR_W'({col_q, {IDX_W{1'b0}}}) + ADDR_W'(idx_q) : '0;
  assign Res_last   = draining & (idx_q == last_idx);
  assign Frame_done = frame_done_q;
  assign Overflow   = overflow_q;

endmodule
